cx4_page_fill: RTL and testbench
================================

Name: cx4_page_fill

Overview:
- Bus-requester engine for the CX4 coprocessor. It fetches one program-cache page from cartridge ROM through the memory-controller read-request handshake (RRQ/RDY/DI).
- Sequential bytes are packed little-endian into 16-bit words and written to the CX4 program-cache RAM.
- Sits between the CX4 core (which requests page loads) and the main memory-controller FSM, which arbitrates PSRAM access and serves the byte reads.

Parameters:
- PAGE_BYTES, 512, bytes per page fill; even, power of two, 2..1024.
- WORD_AW, 8, cache word-address width; equals log2(PAGE_BYTES/2).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- FILL_START  in  1  one-cycle pulse; begin page fill; sampled only in IDLE.
- FILL_ADDR  in  24  ROM byte address of the first byte; latched on an accepted FILL_START.
- FILL_ABORT  in  1  level; stop the fill after the outstanding read completes.
- FILL_BUSY  out  1  high from the cycle after an accepted start until return to IDLE.
- FILL_DONE  out  1  one-cycle pulse after the last word write; not pulsed on abort.
- BUS_ADDR  out  24  ROM byte address of the current request; stable from RRQ until data capture.
- BUS_RRQ  out  1  one-cycle read-request pulse to the memory controller.
- BUS_RDY  in  1  from the memory controller; drops the cycle after RRQ, rises with valid data.
- BUS_DI  in  8  read data; valid in the cycle BUS_RDY is seen high after the wait.
- CACHE_WADDR  out  WORD_AW  cache word address.
- CACHE_WDATA  out  16  {odd byte, even byte}.
- CACHE_WE  out  1  active-high one-cycle write strobe.

Behaviour:
- Reset values: FILL_BUSY=0, FILL_DONE=0, BUS_RRQ=0, CACHE_WE=0, BUS_ADDR=0, CACHE_WADDR=0, CACHE_WDATA=0, byte counter=0, state=IDLE.
- RST mid-fill: return to IDLE at the next edge. No further RRQ is issued. The controller's pending read completes harmlessly and its data is ignored.
- States: IDLE, REQ, HOLD, WAIT, WRITE, FIN.
- IDLE: on FILL_START, latch FILL_ADDR into BUS_ADDR, clear the byte counter, set FILL_BUSY, go to REQ. FILL_START while busy is ignored.
- REQ: assert BUS_RRQ for exactly one cycle, go to HOLD.
- HOLD: ignore BUS_RDY for exactly one cycle, because the controller updates RDY on the edge that samples RRQ. Go to WAIT.
- WAIT: while BUS_RDY=0, stay. When BUS_RDY=1, capture BUS_DI:
  - Even byte index: store in the low holding byte.
  - Odd byte index: form the word {BUS_DI, low}.
  - Then increment BUS_ADDR by 1 (wraps 0xFFFFFF to 0x000000) and the byte counter.
  - Odd byte index: go to WRITE.
  - Even byte index: go to REQ, or to IDLE if FILL_ABORT=1.
- WRITE: CACHE_WE=1 for one cycle with CACHE_WADDR = byte index >> 1.
  - Last word (counter reached PAGE_BYTES): go to FIN.
  - FILL_ABORT=1: go to IDLE. Words already written stay written, no DONE pulse.
  - Otherwise go to REQ.
- FIN: FILL_DONE=1 for one cycle, FILL_BUSY=0 at the same edge, go to IDLE.
- Latency per byte with a zero-wait controller is 3 cycles (REQ, HOLD, WAIT), plus 1 WRITE cycle per word. Minimum page time is PAGE_BYTES*3 + PAGE_BYTES/2 + 1 cycles.
- The byte counter is WORD_AW+2 bits wide so PAGE_BYTES is representable. No wrap within a page.
- At most one request is outstanding at any time. RRQ is never asserted while RDY=0 is expected.
- A new FILL_START is accepted in the cycle after FILL_DONE (IDLE).

Test Plan:
- Model controller: RDY=0 for 7 cycles after RRQ, returns ROM[a]=a[7:0]^0x5A. Start at 0x012300 with PAGE_BYTES=512 -> 256 CACHE_WE pulses; word n = {(0x01+2n)^0x5A, (2n)^0x5A} in low-byte order; FILL_DONE once; BUSY low after DONE.
- RDY held high during HOLD (stale) -> no capture in HOLD; data is taken only after RDY low→high. Check the byte count equals RRQ count.
- FILL_ADDR=0xFFFFFF, PAGE_BYTES=4 -> BUS_ADDR sequence FFFFFF, 000000, 000001, 000002; 2 word writes.
- FILL_ABORT asserted after the 3rd RRQ -> the 3rd byte is captured, no 4th RRQ, no write of word 1, FILL_DONE never pulses, BUSY drops.
- RST during WAIT -> next cycle all outputs at reset values. A late RDY/DI from the model causes no CACHE_WE. A subsequent FILL_START runs a full fill.
- FILL_START pulsed while BUSY -> ignored; BUS_ADDR sequence unaffected; exactly one FILL_DONE.

Source files
------------

// File: rtl/cx4_page_fill.sv
`default_nettype none
// ============================================================================
// Module   : cx4_page_fill
// Brief    : Bus-requester engine that fetches one CX4 program-cache page
//            from cartridge ROM over the RRQ/RDY/DI read handshake. Bytes are
//            packed little-endian into 16-bit words and written to the
//            program-cache RAM.
// Revision : 1.0 - initial release
// ============================================================================
module cx4_page_fill #(
    parameter int PAGE_BYTES = 512,
    parameter int WORD_AW    = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               FILL_START,
    input  logic [23:0]        FILL_ADDR,
    input  logic               FILL_ABORT,
    output logic               FILL_BUSY,
    output logic               FILL_DONE,
    output logic [23:0]        BUS_ADDR,
    output logic               BUS_RRQ,
    input  logic               BUS_RDY,
    input  logic [7:0]         BUS_DI,
    output logic [WORD_AW-1:0] CACHE_WADDR,
    output logic [15:0]        CACHE_WDATA,
    output logic               CACHE_WE
);

    // Byte counter carries two extra bits so that PAGE_BYTES itself fits.
    localparam int                 c_cnt_w      = WORD_AW + 2;
    localparam logic [c_cnt_w-1:0] c_page_bytes = c_cnt_w'(PAGE_BYTES);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_req   = 3'd1;
    localparam logic [2:0] c_st_hold  = 3'd2;
    localparam logic [2:0] c_st_wait  = 3'd3;
    localparam logic [2:0] c_st_write = 3'd4;
    localparam logic [2:0] c_st_fin   = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [23:0]        r_bus_addr;
    logic [c_cnt_w-1:0] r_cnt;
    logic [7:0]         r_low;
    logic [15:0]        r_wdata;
    logic [WORD_AW-1:0] r_waddr;
    logic               w_accept;
    logic               w_capture;
    logic               w_odd;

    assign w_accept  = (r_state == c_st_idle) && FILL_START;
    // RDY is only trusted in WAIT; the HOLD cycle masks the stale value the
    // controller still shows on the edge that samples RRQ.
    assign w_capture = (r_state == c_st_wait) && BUS_RDY;
    assign w_odd     = r_cnt[0];

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; abort is honoured only at byte/word boundaries so the
    // single outstanding read always completes first.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (FILL_START) begin
                    w_state_nxt = c_st_req;
                end
            end
            c_st_req: begin
                w_state_nxt = c_st_hold;
            end
            c_st_hold: begin
                w_state_nxt = c_st_wait;
            end
            c_st_wait: begin
                if (BUS_RDY) begin
                    if (w_odd) begin
                        w_state_nxt = c_st_write;
                    end else if (FILL_ABORT) begin
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_state_nxt = c_st_req;
                    end
                end
            end
            c_st_write: begin
                if (r_cnt == c_page_bytes) begin
                    w_state_nxt = c_st_fin;
                end else if (FILL_ABORT) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_state_nxt = c_st_req;
                end
            end
            c_st_fin: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Address/counter/byte-packing datapath.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bus_addr <= 24'h000000;
            r_cnt      <= '0;
            r_low      <= 8'h00;
            r_wdata    <= 16'h0000;
            r_waddr    <= '0;
        end else begin
            if (w_accept) begin
                r_bus_addr <= FILL_ADDR;
                r_cnt      <= '0;
            end
            if (w_capture) begin
                if (w_odd) begin
                    r_wdata <= {BUS_DI, r_low};
                    r_waddr <= r_cnt[WORD_AW:1];
                end else begin
                    r_low <= BUS_DI;
                end
                r_bus_addr <= r_bus_addr + 24'd1;
                r_cnt      <= r_cnt + c_cnt_one;
            end
        end
    end

    assign FILL_BUSY   = (r_state == c_st_req)  || (r_state == c_st_hold) ||
                         (r_state == c_st_wait) || (r_state == c_st_write);
    assign FILL_DONE   = (r_state == c_st_fin);
    assign BUS_RRQ     = (r_state == c_st_req);
    assign CACHE_WE    = (r_state == c_st_write);
    assign BUS_ADDR    = r_bus_addr;
    assign CACHE_WADDR = r_waddr;
    assign CACHE_WDATA = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cx4_page_fill.sv
`default_nettype none
// ============================================================================
// Module   : tb_cx4_page_fill
// Brief    : Directed self-checking bench for cx4_page_fill. A 512-byte and a
//            4-byte instance share one memory-controller model; sel picks
//            which instance the model serves.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cx4_page_fill;

    logic        CLK = 1'b0;
    logic        RST;
    logic        FILL_START;
    logic [23:0] FILL_ADDR;
    logic        FILL_ABORT;
    logic        BUS_RDY;
    logic [7:0]  BUS_DI;
    logic        sel;

    logic        a_busy, a_done, a_rrq, a_we;
    logic [23:0] a_addr;
    logic [7:0]  a_waddr;
    logic [15:0] a_wdata;
    logic        b_busy, b_done, b_rrq, b_we;
    logic [23:0] b_addr;
    logic [0:0]  b_waddr;
    logic [15:0] b_wdata;

    logic        m_busy_o, m_done_o, m_rrq_o, m_we_o;
    logic [23:0] m_addr_o;
    logic [7:0]  m_waddr_o;
    logic [15:0] m_wdata_o;

    // clock
    always #5 CLK = ~CLK;

    cx4_page_fill #(.PAGE_BYTES(512), .WORD_AW(8)) u_dut512 (
        .CLK(CLK), .RST(RST), .FILL_START(FILL_START & ~sel), .FILL_ADDR(FILL_ADDR),
        .FILL_ABORT(FILL_ABORT), .FILL_BUSY(a_busy), .FILL_DONE(a_done),
        .BUS_ADDR(a_addr), .BUS_RRQ(a_rrq), .BUS_RDY(sel ? 1'b1 : BUS_RDY),
        .BUS_DI(BUS_DI), .CACHE_WADDR(a_waddr), .CACHE_WDATA(a_wdata), .CACHE_WE(a_we)
    );

    cx4_page_fill #(.PAGE_BYTES(4), .WORD_AW(1)) u_dut4 (
        .CLK(CLK), .RST(RST), .FILL_START(FILL_START & sel), .FILL_ADDR(FILL_ADDR),
        .FILL_ABORT(FILL_ABORT), .FILL_BUSY(b_busy), .FILL_DONE(b_done),
        .BUS_ADDR(b_addr), .BUS_RRQ(b_rrq), .BUS_RDY(sel ? BUS_RDY : 1'b1),
        .BUS_DI(BUS_DI), .CACHE_WADDR(b_waddr), .CACHE_WDATA(b_wdata), .CACHE_WE(b_we)
    );

    assign m_busy_o  = sel ? b_busy  : a_busy;
    assign m_done_o  = sel ? b_done  : a_done;
    assign m_rrq_o   = sel ? b_rrq   : a_rrq;
    assign m_we_o    = sel ? b_we    : a_we;
    assign m_addr_o  = sel ? b_addr  : a_addr;
    assign m_waddr_o = sel ? {7'b0, b_waddr} : a_waddr;
    assign m_wdata_o = sel ? b_wdata : a_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    // memory-controller model: RDY drops m_drop cycles after RRQ is seen and
    // rises m_lat cycles later with ROM[a] = a[7:0] ^ 0x5A
    int          m_lat   = 7;
    bit          m_stale = 1'b0;
    bit          m_pend  = 1'b0;
    int          m_t     = 0;
    int          m_drop  = 0;
    logic [23:0] m_req;
    int          prot_err = 0;

    always @(negedge CLK) begin
        if (m_rrq_o && m_pend) prot_err++;
        if (m_pend) begin
            m_t = m_t + 1;
            if (m_t == m_drop) BUS_RDY = 1'b0;
            if (m_t == m_drop + m_lat) begin
                BUS_RDY = 1'b1;
                BUS_DI  = m_req[7:0] ^ 8'h5A;
                m_pend  = 1'b0;
            end
        end else if (m_rrq_o) begin
            m_pend = 1'b1;
            m_t    = 0;
            m_req  = m_addr_o;
            m_drop = m_stale ? 2 : 0;
            if (!m_stale) BUS_RDY = 1'b0;
        end
    end

    // monitor of the selected instance
    int          rrq_count = 0, we_count = 0, done_count = 0, busy_cycles = 0;
    logic [23:0] addr_log [0:1023];
    logic [7:0]  wa_log   [0:511];
    logic [15:0] wd_log   [0:511];

    always @(negedge CLK) begin
        if (m_rrq_o) begin
            if (rrq_count < 1024) addr_log[rrq_count] = m_addr_o;
            rrq_count++;
        end
        if (m_we_o) begin
            if (we_count < 512) begin
                wa_log[we_count] = m_waddr_o;
                wd_log[we_count] = m_wdata_o;
            end
            we_count++;
        end
        if (m_done_o) done_count++;
        if (m_busy_o) busy_cycles++;
    end

    task automatic clear_logs();
        rrq_count = 0; we_count = 0; done_count = 0; busy_cycles = 0;
    endtask

    task automatic start_fill(input logic [23:0] addr);
        @(negedge CLK);
        FILL_ADDR  = addr;
        FILL_START = 1'b1;
        @(negedge CLK);
        FILL_START = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while ((m_busy_o || m_done_o) && k < budget) begin
            @(negedge CLK);
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            $display("FAIL %s_timeout: still busy after %0d cycles", tag, k);
        end
    endtask

    task automatic wait_model(input string tag);
        int k = 0;
        while (m_pend && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            $display("FAIL %s_model_timeout: controller still pending", tag);
        end
    endtask

    task automatic wait_rrq(input int n, input string tag);
        int k = 0;
        while (rrq_count < n && k < 500) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 500) begin
            n_checks++;
            $display("FAIL %s_rrq_timeout: rrq_count=%0d wanted %0d", tag, rrq_count, n);
        end
    endtask

    task automatic test_reset();
        logic [59:0] got;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            got = {m_busy_o, m_done_o, m_rrq_o, m_we_o, m_addr_o, m_waddr_o, m_wdata_o};
            n_checks++;
            if (got !== 60'h0) $display("FAIL reset_outputs_%0d: got %h expected 0", s, got);
            else n_pass++;
        end
        sel = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (a_busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", a_busy);
        else n_pass++;
    endtask

    task automatic test_full_page(input logic [23:0] base, input int lat, input string tag);
        logic [23:0] a;
        logic [23:0] exp;
        sel = 1'b0; m_lat = lat; m_stale = 1'b0;
        clear_logs();
        start_fill(base);
        wait_idle(20000, tag);
        n_checks++;
        if (we_count !== 256) $display("FAIL %s_we_count: got %0d expected 256", tag, we_count);
        else n_pass++;
        n_checks++;
        if (rrq_count !== 512) $display("FAIL %s_rrq_count: got %0d expected 512", tag, rrq_count);
        else n_pass++;
        n_checks++;
        if (done_count !== 1) $display("FAIL %s_done_count: got %0d expected 1", tag, done_count);
        else n_pass++;
        n_checks++;
        if (a_busy !== 1'b0) $display("FAIL %s_busy_after: got %b expected 0", tag, a_busy);
        else n_pass++;
        exp = base + 24'd512;
        n_checks++;
        if (a_addr !== exp) $display("FAIL %s_end_addr: got %h expected %h", tag, a_addr, exp);
        else n_pass++;
        for (int n = 0; n < 256; n++) begin
            a = base + 24'(2 * n);
            exp = {n[7:0], (a[7:0] + 8'd1) ^ 8'h5A, a[7:0] ^ 8'h5A};
            n_checks++;
            if ({wa_log[n], wd_log[n]} !== exp)
                $display("FAIL %s_word_%0d: got %h expected %h", tag, n, {wa_log[n], wd_log[n]}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_rst_mid();
        sel = 1'b0; m_lat = 7; m_stale = 1'b0;
        clear_logs();
        start_fill(24'h000234);
        wait_rrq(1, "rst_mid");
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        n_checks++;
        if ({a_busy, a_done, a_rrq, a_we, a_addr, a_waddr, a_wdata} !== 52'h0)
            $display("FAIL rst_mid_outputs: got %h expected 0",
                     {a_busy, a_done, a_rrq, a_we, a_addr, a_waddr, a_wdata});
        else n_pass++;
        wait_model("rst_mid");
        repeat (2) @(negedge CLK);
        n_checks++;
        if (we_count !== 0) $display("FAIL rst_mid_late_we: got %0d expected 0", we_count);
        else n_pass++;
        n_checks++;
        if (rrq_count !== 1) $display("FAIL rst_mid_rrq: got %0d expected 1", rrq_count);
        else n_pass++;
        test_full_page(24'h000300, 1, "rst_refill");
    endtask

    task automatic test_abort();
        sel = 1'b0; m_lat = 7; m_stale = 1'b0;
        clear_logs();
        start_fill(24'h000010);
        wait_rrq(3, "abort");
        FILL_ABORT = 1'b1;
        wait_idle(200, "abort");
        repeat (12) @(negedge CLK);
        FILL_ABORT = 1'b0;
        n_checks++;
        if (rrq_count !== 3) $display("FAIL abort_rrq: got %0d expected 3", rrq_count);
        else n_pass++;
        n_checks++;
        if (we_count !== 1) $display("FAIL abort_we: got %0d expected 1", we_count);
        else n_pass++;
        n_checks++;
        if (wd_log[0] !== 16'h4B4A) $display("FAIL abort_word0: got %h expected 4b4a", wd_log[0]);
        else n_pass++;
        n_checks++;
        if (done_count !== 0) $display("FAIL abort_done: got %0d expected 0", done_count);
        else n_pass++;
        n_checks++;
        if (a_busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", a_busy);
        else n_pass++;
        n_checks++;
        if (a_addr !== 24'h000013) $display("FAIL abort_addr: got %h expected 000013", a_addr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        sel = 1'b1; m_lat = 1; m_stale = 1'b0;
        clear_logs();
        start_fill(24'hFFFFFF);
        wait_idle(200, "wrap");
        n_checks++;
        if ({addr_log[0], addr_log[1], addr_log[2], addr_log[3]} !== 96'hFFFFFF_000000_000001_000002)
            $display("FAIL wrap_addr_seq: got %h %h %h %h expected ffffff 000000 000001 000002",
                     addr_log[0], addr_log[1], addr_log[2], addr_log[3]);
        else n_pass++;
        n_checks++;
        if (we_count !== 2) $display("FAIL wrap_we: got %0d expected 2", we_count);
        else n_pass++;
        n_checks++;
        if ({wa_log[0], wd_log[0], wa_log[1], wd_log[1]} !== 48'h00_5AA5_01_585B)
            $display("FAIL wrap_words: got %h %h %h %h expected 00 5aa5 01 585b",
                     wa_log[0], wd_log[0], wa_log[1], wd_log[1]);
        else n_pass++;
        n_checks++;
        if (busy_cycles !== 14) $display("FAIL wrap_busy_cycles: got %0d expected 14", busy_cycles);
        else n_pass++;
        n_checks++;
        if (done_count !== 1) $display("FAIL wrap_done: got %0d expected 1", done_count);
        else n_pass++;
    endtask

    task automatic test_stale();
        sel = 1'b1; m_lat = 3; m_stale = 1'b1;
        clear_logs();
        start_fill(24'h000040);
        wait_idle(300, "stale");
        wait_model("stale");
        m_stale = 1'b0;
        n_checks++;
        if (rrq_count !== 4) $display("FAIL stale_rrq: got %0d expected 4", rrq_count);
        else n_pass++;
        n_checks++;
        if (we_count * 2 !== rrq_count) $display("FAIL stale_bytes: got %0d bytes expected %0d", we_count * 2, rrq_count);
        else n_pass++;
        n_checks++;
        if ({wd_log[0], wd_log[1]} !== 32'h1B1A_1918)
            $display("FAIL stale_words: got %h %h expected 1b1a 1918", wd_log[0], wd_log[1]);
        else n_pass++;
    endtask

    task automatic test_busy_start();
        sel = 1'b1; m_lat = 3; m_stale = 1'b0;
        clear_logs();
        start_fill(24'h001000);
        wait_rrq(2, "busy_start");
        FILL_ADDR  = 24'hABCDEF;
        FILL_START = 1'b1;
        @(negedge CLK);
        FILL_START = 1'b0;
        wait_idle(300, "busy_start");
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({addr_log[0], addr_log[1], addr_log[2], addr_log[3]} !== 96'h001000_001001_001002_001003)
            $display("FAIL busy_start_addr_seq: got %h %h %h %h expected 001000 001001 001002 001003",
                     addr_log[0], addr_log[1], addr_log[2], addr_log[3]);
        else n_pass++;
        n_checks++;
        if (rrq_count !== 4) $display("FAIL busy_start_rrq: got %0d expected 4", rrq_count);
        else n_pass++;
        n_checks++;
        if (done_count !== 1) $display("FAIL busy_start_done: got %0d expected 1", done_count);
        else n_pass++;
        n_checks++;
        if ({wd_log[0], wd_log[1]} !== 32'h5B5A_5958)
            $display("FAIL busy_start_words: got %h %h expected 5b5a 5958", wd_log[0], wd_log[1]);
        else n_pass++;
    endtask

    initial begin
        FILL_START = 1'b0;
        FILL_ADDR  = 24'h0;
        FILL_ABORT = 1'b0;
        BUS_RDY    = 1'b1;
        BUS_DI     = 8'h00;
        sel        = 1'b0;
        RST        = 1'b1;
        test_reset();
        test_full_page(24'h012300, 7, "full_page");
        test_rst_mid();
        test_abort();
        test_wrap();
        test_stale();
        test_busy_start();
        n_checks++;
        if (prot_err !== 0) $display("FAIL rrq_while_pending: got %0d expected 0", prot_err);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
